// File: rtl/bank_cmd_gen_if.sv
// Request/command bundle between a bank_cmd_gen instance and its neighbours.
// Latency: none; this is wiring only.
// Backpressure: req_ready from the bank gates requests; grant from the arbiter issues commands.
interface bank_cmd_gen_if #(
  parameter int CMD_TYPE_WIDTH = 3,
  parameter int ROW_WIDTH      = 16,
  parameter int COL_WIDTH      = 10,
  parameter int QWIDTH         = CMD_TYPE_WIDTH + ROW_WIDTH
);
  logic                 req_valid;
  logic                 req_ready;
  logic [ROW_WIDTH-1:0] req_row;
  logic [COL_WIDTH-1:0] req_col;
  logic                 req_we;
  logic                 cmd_valid;
  logic [QWIDTH-1:0]    cmd_word;
  logic                 grant;
  logic                 row_open;
  logic [ROW_WIDTH-1:0] open_row;

  // Requester plus arbiter side.
  modport master (
    output req_valid, req_row, req_col, req_we, grant,
    input  req_ready, cmd_valid, cmd_word, row_open, open_row
  );

  // Bank command generator side.
  modport slave (
    input  req_valid, req_row, req_col, req_we, grant,
    output req_ready, cmd_valid, cmd_word, row_open, open_row
  );
endinterface

// File: rtl/bank_cmd_gen.sv
// Per-bank command generator: holds one request, tracks open row and tRCD/tRP/tRAS/tWR, offers one command.
// Latency: accepted request offers its first command the next cycle; timers gate ACT/RD/WR/PRE.
// Backpressure: req_ready low while a request is pending, except in the cycle its RD/WR is granted.
module bank_cmd_gen #(
  parameter int CMD_TYPE_WIDTH = 3,
  parameter int ROW_WIDTH      = 16,
  parameter int COL_WIDTH      = 10,
  parameter int QWIDTH         = CMD_TYPE_WIDTH + ROW_WIDTH,
  parameter int T_RCD          = 14,
  parameter int T_RP           = 14,
  parameter int T_RAS          = 32,
  parameter int T_WR           = 15,
  parameter int CNT_WIDTH      = 6
) (
  input  logic          clk,
  input  logic          rst,
  bank_cmd_gen_if.slave bus
);

  localparam logic [CMD_TYPE_WIDTH-1:0] CMD_NOP = CMD_TYPE_WIDTH'(0);
  localparam logic [CMD_TYPE_WIDTH-1:0] CMD_ACT = CMD_TYPE_WIDTH'(1);
  localparam logic [CMD_TYPE_WIDTH-1:0] CMD_PRE = CMD_TYPE_WIDTH'(2);
  localparam logic [CMD_TYPE_WIDTH-1:0] CMD_RD  = CMD_TYPE_WIDTH'(3);
  localparam logic [CMD_TYPE_WIDTH-1:0] CMD_WR  = CMD_TYPE_WIDTH'(4);

  localparam logic [CNT_WIDTH-1:0] RCD_LOAD = CNT_WIDTH'(T_RCD - 1);
  localparam logic [CNT_WIDTH-1:0] RP_LOAD  = CNT_WIDTH'(T_RP - 1);
  localparam logic [CNT_WIDTH-1:0] RAS_LOAD = CNT_WIDTH'(T_RAS - 1);
  localparam logic [CNT_WIDTH-1:0] WR_LOAD  = CNT_WIDTH'(T_WR - 1);

  typedef enum logic {
    ST_CLOSED = 1'b0,
    ST_OPEN   = 1'b1
  } bank_st_e;

  bank_st_e             state_q, state_d;
  logic                 pend_q, pend_d;
  logic [ROW_WIDTH-1:0] row_q, row_d;
  logic [COL_WIDTH-1:0] col_q, col_d;
  logic                 we_q, we_d;
  logic [ROW_WIDTH-1:0] open_row_q, open_row_d;
  logic [CNT_WIDTH-1:0] rcd_q, rcd_d;
  logic [CNT_WIDTH-1:0] rp_q, rp_d;
  logic [CNT_WIDTH-1:0] ras_q, ras_d;
  logic [CNT_WIDTH-1:0] wr_q, wr_d;

  logic                      cmd_vld;
  logic [CMD_TYPE_WIDTH-1:0] cmd_type;
  logic [ROW_WIDTH-1:0]      cmd_addr;
  logic                      issue;
  logic                      col_done;
  logic                      req_rdy;
  logic                      accept;

  // Saturating down-count used by every timing counter that is not being reloaded.
  function automatic logic [CNT_WIDTH-1:0] cnt_dec(input logic [CNT_WIDTH-1:0] c);
    return (c == '0) ? c : c - CNT_WIDTH'(1);
  endfunction

  // Pick the one command this bank can offer, purely from registered state.
  always_comb begin
    cmd_vld  = 1'b0;
    cmd_type = CMD_NOP;
    cmd_addr = '0;
    if (pend_q) begin
      if (state_q == ST_CLOSED) begin
        if (rp_q == '0) begin
          cmd_vld  = 1'b1;
          cmd_type = CMD_ACT;
          cmd_addr = row_q;
        end
      end else if (open_row_q == row_q) begin
        if (rcd_q == '0) begin
          cmd_vld  = 1'b1;
          cmd_type = we_q ? CMD_WR : CMD_RD;
          cmd_addr = ROW_WIDTH'(col_q);
        end
      end else if ((ras_q == '0) && (wr_q == '0)) begin
        cmd_vld  = 1'b1;
        cmd_type = CMD_PRE;
      end
    end
  end

  // A granted RD/WR retires the request, so a new one may land on the same edge.
  assign issue    = bus.grant & cmd_vld;
  assign col_done = issue & ((cmd_type == CMD_RD) | (cmd_type == CMD_WR));
  assign req_rdy  = ~pend_q | col_done;
  assign accept   = bus.req_valid & req_rdy;

  // Next-state: timers count down, a granted command updates bank tracking, accepts load the request.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    row_d      = row_q;
    col_d      = col_q;
    we_d       = we_q;
    open_row_d = open_row_q;
    rcd_d      = cnt_dec(rcd_q);
    rp_d       = cnt_dec(rp_q);
    ras_d      = cnt_dec(ras_q);
    wr_d       = cnt_dec(wr_q);
    if (issue) begin
      case (cmd_type)
        CMD_ACT: begin
          state_d    = ST_OPEN;
          open_row_d = row_q;
          rcd_d      = RCD_LOAD;
          ras_d      = RAS_LOAD;
        end
        CMD_RD: begin
          pend_d = 1'b0;
        end
        CMD_WR: begin
          pend_d = 1'b0;
          wr_d   = WR_LOAD;
        end
        CMD_PRE: begin
          state_d    = ST_CLOSED;
          open_row_d = '0;
          rp_d       = RP_LOAD;
        end
        default: begin
        end
      endcase
    end
    if (accept) begin
      pend_d = 1'b1;
      row_d  = bus.req_row;
      col_d  = bus.req_col;
      we_d   = bus.req_we;
    end
  end

  // Bank FSM and request/timer registers; reset drops the request and forgets the open row.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CLOSED;
      pend_q     <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      we_q       <= 1'b0;
      open_row_q <= '0;
      rcd_q      <= '0;
      rp_q       <= '0;
      ras_q      <= '0;
      wr_q       <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      row_q      <= row_d;
      col_q      <= col_d;
      we_q       <= we_d;
      open_row_q <= open_row_d;
      rcd_q      <= rcd_d;
      rp_q       <= rp_d;
      ras_q      <= ras_d;
      wr_q       <= wr_d;
    end
  end

  assign bus.req_ready = req_rdy;
  assign bus.cmd_valid = cmd_vld;
  assign bus.cmd_word  = {cmd_addr, cmd_type};
  assign bus.row_open  = (state_q == ST_OPEN);
  assign bus.open_row  = open_row_q;

endmodule
